// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation encodings,
// datapath width, default latencies and the FSM state type.
package md_pkg;

    localparam int MD_W             = 32;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_calc_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_if.sv
// E-stage side of the multiply/divide unit: operation request, forwarded operands
// and the HI/LO, busy and result outputs.
interface md_if
    import md_pkg::*;
();
    md_op_e            md_op;
    logic              start;
    logic [MD_W-1:0]   for_rs_E;
    logic [MD_W-1:0]   for_rt_E;
    logic              busy;
    logic              md_active;
    logic [MD_W-1:0]   hi;
    logic [MD_W-1:0]   lo;
    logic [MD_W-1:0]   md_out;

    modport master (
        output md_op, start, for_rs_E, for_rt_E,
        input  busy, md_active, hi, lo, md_out
    );

    modport slave (
        input  md_op, start, for_rs_E, for_rt_E,
        output busy, md_active, hi, lo, md_out
    );
endinterface

// File: rtl/md_calc.sv
// Combinational 32x32 multiply and divide producing the 64-bit {hi,lo} result
// plus a divide-by-zero flag.
module md_calc
    import md_pkg::*;
(
    input  md_op_e           op,
    input  logic [MD_W-1:0]  a,
    input  logic [MD_W-1:0]  b,
    output logic [MD_W-1:0]  res_hi,
    output logic [MD_W-1:0]  res_lo,
    output logic             div0
);

    logic [2*MD_W-1:0] prod_s;
    logic [2*MD_W-1:0] prod_u;
    logic              div_signed;
    logic [MD_W-1:0]   a_mag;
    logic [MD_W-1:0]   b_mag;
    logic [MD_W-1:0]   b_safe;
    logic [MD_W-1:0]   q_mag;
    logic [MD_W-1:0]   r_mag;
    logic [MD_W-1:0]   quot;
    logic [MD_W-1:0]   rem;

    assign prod_s = $signed({{MD_W{a[MD_W-1]}}, a}) * $signed({{MD_W{b[MD_W-1]}}, b});
    assign prod_u = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};

    // Signed division works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    assign div_signed = (op == MD_DIV);
    assign a_mag  = (div_signed && a[MD_W-1]) ? (~a + 1'b1) : a;
    assign b_mag  = (div_signed && b[MD_W-1]) ? (~b + 1'b1) : b;
    assign b_safe = (b_mag == '0) ? {{(MD_W-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (div_signed && (a[MD_W-1] ^ b[MD_W-1])) ? (~q_mag + 1'b1) : q_mag;
    assign rem    = (div_signed && a[MD_W-1]) ? (~r_mag + 1'b1) : r_mag;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        div0   = 1'b0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                div0   = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div sequencing, HI/LO ownership
// and the mthi/mtlo/mfhi/mflo paths.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state;
    md_state_e         state_next;
    logic [CNT_W-1:0]  count;
    logic [MD_W-1:0]   res_hi;
    logic [MD_W-1:0]   res_lo;
    logic              div0_q;
    logic [MD_W-1:0]   hi_q;
    logic [MD_W-1:0]   lo_q;

    logic [MD_W-1:0]   calc_hi;
    logic [MD_W-1:0]   calc_lo;
    logic              calc_div0;
    logic              idle_req;
    logic              accept;
    logic              done;

    md_calc u_calc (
        .op     (bus.md_op),
        .a      (bus.for_rs_E),
        .b      (bus.for_rt_E),
        .res_hi (calc_hi),
        .res_lo (calc_lo),
        .div0   (calc_div0)
    );

    assign idle_req = bus.start && (state == ST_IDLE);
    assign accept   = idle_req && is_calc_op(bus.md_op);
    assign done     = (state == ST_BUSY) && (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_BUSY;
            ST_BUSY: if (done)   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The result is captured at accept time, so operand changes while busy cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
            div0_q <= 1'b0;
        end else if (accept) begin
            count  <= is_mult_op(bus.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            res_hi <= calc_hi;
            res_lo <= calc_lo;
            div0_q <= calc_div0;
        end else if (state == ST_BUSY) begin
            count  <= count - CNT_W'(1);
        end
    end

    // A divide by zero still runs its full latency but leaves HI/LO untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (done) begin
            if (!div0_q) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (idle_req && (bus.md_op == MD_MTHI)) begin
            hi_q <= bus.for_rs_E;
        end else if (idle_req && (bus.md_op == MD_MTLO)) begin
            lo_q <= bus.for_rs_E;
        end
    end

    always_comb begin
        bus.md_out = '0;
        if (bus.start && (bus.md_op == MD_MFHI)) bus.md_out = hi_q;
        if (bus.start && (bus.md_op == MD_MFLO)) bus.md_out = lo_q;
    end

    assign bus.busy      = (state == ST_BUSY);
    assign bus.md_active = (state == ST_BUSY) || (bus.start && is_calc_op(bus.md_op));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed test of md_unit: reset abort, mult/div latency and arithmetic,
// divide corner cases, mthi/mtlo/mfhi/mflo and back-to-back acceptance.
module tb_md_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    md_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic apply_stimulus(input md_op_e op, input logic st,
                                  input logic [31:0] rs, input logic [31:0] rt);
        bus.md_op    = op;
        bus.start    = st;
        bus.for_rs_E = rs;
        bus.for_rt_E = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("[TB] check %s failed", tag);
        end
    endtask

    // Issue one op, follow it through n busy cycles, then check the final HI/LO.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        apply_stimulus(op, 1'b1, a, b);
        #1;
        check_output({tag, "_active_accept"}, {31'b0, bus.md_active}, 32'd1);
        tick();
        apply_stimulus(MD_NONE, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            check_output({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
            tick();
        end
        check_output({tag, "_busy_drop"}, {31'b0, bus.busy}, 32'd0);
        check_output({tag, "_hi"}, bus.hi, exp_hi);
        check_output({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(MD_NONE, 1'b0, 32'h0, 32'h0);
        #12;
        check_output("rst_busy", {31'b0, bus.busy}, 32'd0);
        check_output("rst_hi", bus.hi, 32'h0);
        check_output("rst_lo", bus.lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] reset during MULT");
        apply_stimulus(MD_MULT, 1'b1, 32'd3, 32'd4);
        tick();
        apply_stimulus(MD_NONE, 1'b0, 32'h0, 32'h0);
        tick();
        check_output("midrst_busy_before", {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check_output("midrst_hi", bus.hi, 32'h0);
        check_output("midrst_lo", bus.lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        check_output("midrst_after_busy", {31'b0, bus.busy}, 32'd0);
        check_output("midrst_after_lo", bus.lo, 32'h0);
        check_output("midrst_after_hi", bus.hi, 32'h0);

        $display("[TB] multiply");
        run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE);

        $display("[TB] divide");
        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", MD_DIVU, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

        apply_stimulus(MD_MTHI, 1'b1, 32'h00000011, 32'h0);
        tick();
        apply_stimulus(MD_MTLO, 1'b1, 32'h00000022, 32'h0);
        tick();
        run_op("divu0", MD_DIVU, 32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022);

        $display("[TB] move to/from hi/lo");
        apply_stimulus(MD_MTHI, 1'b1, 32'hA5A5A5A5, 32'h0);
        tick();
        apply_stimulus(MD_MFHI, 1'b1, 32'h0, 32'h0);
        #1;
        check_output("mfhi", bus.md_out, 32'hA5A5A5A5);
        apply_stimulus(MD_MFHI, 1'b0, 32'h0, 32'h0);
        #1;
        check_output("mfhi_nostart", bus.md_out, 32'h0);
        apply_stimulus(MD_MFLO, 1'b1, 32'h0, 32'h0);
        #1;
        check_output("mflo", bus.md_out, 32'h00000022);

        apply_stimulus(MD_MULT, 1'b1, 32'd2, 32'd3);
        tick();
        apply_stimulus(MD_MTLO, 1'b1, 32'h0000DEAD, 32'h0);
        tick();
        check_output("mtlo_busy_lo", bus.lo, 32'h00000022);
        apply_stimulus(MD_MFLO, 1'b1, 32'h0, 32'h0);
        #1;
        check_output("mflo_busy_stale", bus.md_out, 32'h00000022);
        apply_stimulus(MD_NONE, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        check_output("mtlo_busy_done", {31'b0, bus.busy}, 32'd0);
        check_output("mtlo_busy_res_lo", bus.lo, 32'd6);
        check_output("mtlo_busy_res_hi", bus.hi, 32'd0);

        $display("[TB] back-to-back");
        apply_stimulus(MD_MULT, 1'b1, 32'd3, 32'd5);
        tick();
        apply_stimulus(MD_MULT, 1'b1, 32'd7, 32'd7);
        for (int i = 0; i < 5; i++) begin
            check_output("b2b_busy", {31'b0, bus.busy}, 32'd1);
            check_output("b2b_active", {31'b0, bus.md_active}, 32'd1);
            tick();
        end
        apply_stimulus(MD_MULT, 1'b1, 32'd9, 32'd9);
        #1;
        check_output("b2b_drop_busy", {31'b0, bus.busy}, 32'd0);
        check_output("b2b_drop_active", {31'b0, bus.md_active}, 32'd1);
        check_output("b2b_first_lo", bus.lo, 32'd15);
        check_output("b2b_first_hi", bus.hi, 32'd0);
        tick();
        check_output("b2b_rebusy", {31'b0, bus.busy}, 32'd1);
        apply_stimulus(MD_NONE, 1'b0, 32'h0, 32'h0);
        repeat (5) tick();
        check_output("b2b_second_busy", {31'b0, bus.busy}, 32'd0);
        check_output("b2b_second_lo", bus.lo, 32'd81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
